dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL expose parameter STARVE_LIMIT, default 4, the number of consecutive lost arbitrations after which port 1 takes priority.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0/req1, input, 1 bit each: access request from port 0 (CPU MEM stage) and port 1 (DMA/debug).
REQ-005 The block SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports addr0/addr1, input, 32 bits each: byte address.
REQ-007 The block SHALL have ports wdata0/wdata1, input, 32 bits each: write data, byte-lane aligned.
REQ-008 The block SHALL have ports be0/be1, input, 4 bits each: byte enables, bit n selects wdata[8n+7:8n].
REQ-009 The block SHALL have ports ack0/ack1, output, 1 bit each: one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, 32 bits: read word, valid while ack0 or ack1 is high.
REQ-011 The block SHALL have ports mem_A, output, 32 bits; mem_WD, output, 32 bits; mem_we, output, 1 bit: data-memory drive.
REQ-012 The block SHALL have port mem_DR, input, 32 bits: combinational memory read data.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have three states: IDLE, ACCESS and MERGE.
REQ-015 In IDLE with at least one eligible request, the block SHALL latch the winner's id, we, addr, wdata and be, then go to ACCESS.
REQ-016 A requester whose ack is high in the current cycle SHALL be ineligible in that cycle.
REQ-017 Arbitration SHALL be fixed-priority to port 0, except that port 1 wins a simultaneous request when starve_cnt equals STARVE_LIMIT.
REQ-018 starve_cnt SHALL increment, saturating at STARVE_LIMIT, when port 1 is requesting and eligible but port 0 is granted.
REQ-019 starve_cnt SHALL clear to 0 whenever port 1 is granted.
REQ-020 mem_A SHALL equal {latched_addr[31:2], 2'b00} in ACCESS and MERGE, and 0 in IDLE.
REQ-021 ACCESS, read: mem_we = 0; at the next edge, rdata <= mem_DR, pulse the winner's ack, go to IDLE.
REQ-022 ACCESS, write with be == 4'hF: mem_we = 1 and mem_WD = latched wdata; at the next edge, pulse ack and go to IDLE.
REQ-023 ACCESS, write with be == 4'h0: mem_we = 0; at the next edge, pulse ack and go to IDLE (no-op).
REQ-024 ACCESS, write with any other be: mem_we = 0; at the next edge, capture mem_DR into the merge register and go to MERGE.
REQ-025 In MERGE, mem_WD SHALL be built per byte lane n as be[n] ? wdata lane n : merge-register lane n, with mem_we = 1.
REQ-026 At the edge leaving MERGE, the block SHALL pulse ack and go to IDLE.
REQ-027 mem_WD SHALL be 0 whenever mem_we = 0.
REQ-028 ack0/ack1 SHALL be registered, high for exactly one cycle per grant, and never high together.
REQ-029 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-030 Latency from request seen in IDLE to ack high SHALL be 2 edges for reads, full writes and no-op writes, and 3 edges for partial writes.
REQ-031 A requester SHALL hold req and its operands stable until its ack; operand changes after the grant edge SHALL be ignored.
REQ-032 A request dropped before ack SHALL still complete its access; the ack is issued regardless.

Reset
REQ-033 Asserting reset SHALL immediately force state = IDLE, ack0 = ack1 = 0, rdata = 0, starve_cnt = 0, merge register = 0, mem_we = 0, mem_A = 0, mem_WD = 0 and busy = 0.
REQ-034 Reset asserted in ACCESS or MERGE SHALL abort the transaction with no memory write and no ack.

Verification
REQ-035 Scenario: req0 read at 0x10 with mem word 0xDEADBEEF -> ack0 two edges later, rdata = 0xDEADBEEF, mem_we never high.
REQ-036 Scenario: req1 write addr 0x22, be = 4'b1100, wdata = 0x12340000, memory word 0xAABBCCDD -> one MERGE cycle with mem_A = 0x20, mem_WD = 0x1234CCDD, ack1 on the third edge.
REQ-037 Scenario: req0 and req1 held continuously with STARVE_LIMIT = 4 -> four port-0 grants, then one port-1 grant, with starve_cnt returning to 0.
REQ-038 Scenario: write with be = 4'h0 -> ack after 2 edges, mem_we = 0 throughout.
REQ-039 Scenario: reset pulsed during MERGE -> no mem_we pulse, no ack, busy = 0 immediately; a following read completes normally.
REQ-040 Scenario: req0 held high across its own ack with req1 pending -> port 1 is granted in the ack cycle, with no duplicate port-0 grant.

Source files
------------

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port data-memory arbiter.
// Port 0 (CPU MEM stage) has fixed priority. Port 1 (DMA/debug) takes a
// simultaneous request once it has lost STARVE_LIMIT arbitrations in a row.
// Partial-byte writes are done as read-merge-write over two cycles.
module dm_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_we,
    input  logic [31:0] mem_DR,
    output logic        busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2
    } state_t;

    state_t           state;
    logic             lat_id;      // 0 = port 0, 1 = port 1
    logic             lat_we;
    logic [31:0]      lat_wdata;
    logic [3:0]       lat_be;
    logic [31:0]      merge_reg;
    logic [CNT_W-1:0] starve_cnt;

    logic             elig0;
    logic             elig1;
    logic             win;
    logic             grant;
    logic             win_we;
    logic [31:0]      win_addr;
    logic [31:0]      win_wdata;
    logic [3:0]       win_be;

    // Per byte lane: take the new write data where enabled, keep the old word elsewhere.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  be,
                                                input logic [31:0] wdata,
                                                input logic [31:0] old);
        logic [31:0] r;
        for (int n = 0; n < 4; n++) begin
            r[8*n +: 8] = be[n] ? wdata[8*n +: 8] : old[8*n +: 8];
        end
        return r;
    endfunction

    // Arbitration: a port being acked this cycle cannot win again in the same cycle.
    always_comb begin
        elig0 = req0 && !ack0;
        elig1 = req1 && !ack1;
        win   = elig1 && (!elig0 || (starve_cnt == CNT_MAX));
        grant = (state == IDLE) && (elig0 || elig1);
        if (win) begin
            win_we    = we1;
            win_addr  = addr1;
            win_wdata = wdata1;
            win_be    = be1;
        end else begin
            win_we    = we0;
            win_addr  = addr0;
            win_wdata = wdata0;
            win_be    = be0;
        end
    end

    // Main FSM: latches the winner, drives the memory, and issues the ack pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata      <= '0;
            starve_cnt <= '0;
            merge_reg  <= '0;
            mem_we     <= 1'b0;
            mem_A      <= '0;
            lat_id     <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            lat_be     <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        lat_id    <= win;
                        lat_we    <= win_we;
                        lat_wdata <= win_wdata;
                        lat_be    <= win_be;
                        // Low address bits are masked off: memory is word addressed.
                        mem_A     <= win_addr & ~32'h3;
                        // Only a full-word write drives the memory in ACCESS.
                        mem_we    <= win_we && (win_be == 4'hF);
                        state     <= ACCESS;
                        if (win) begin
                            starve_cnt <= '0;
                        end else if (elig1 && (starve_cnt != CNT_MAX)) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (lat_we && (lat_be != 4'hF) && (lat_be != 4'h0)) begin
                        // Partial write: hold the old word and write the merged one next cycle.
                        merge_reg <= mem_DR;
                        mem_we    <= 1'b1;
                        state     <= MERGE;
                    end else begin
                        if (!lat_we) begin
                            rdata <= mem_DR;
                        end
                        ack0   <= !lat_id;
                        ack1   <= lat_id;
                        mem_we <= 1'b0;
                        mem_A  <= '0;
                        state  <= IDLE;
                    end
                end
                MERGE: begin
                    ack0   <= !lat_id;
                    ack1   <= lat_id;
                    mem_we <= 1'b0;
                    mem_A  <= '0;
                    state  <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    mem_A  <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Write data is assembled from registered state only and is zero whenever no write is driven.
    assign mem_WD = !mem_we          ? 32'h0 :
                    (state == MERGE) ? merge_bytes(lat_be, lat_wdata, merge_reg) :
                                       lat_wdata;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a small behavioural data memory.
module tb_dm_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        ack0, ack1;
    logic [31:0] rdata, mem_A, mem_WD, mem_DR;
    logic        mem_we, busy;

    logic [31:0] mem [0:63];
    logic        mem_load;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          port;
        logic        chk_rd;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    dm_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .be0(be0), .be1(be1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_we(mem_we), .mem_DR(mem_DR),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural word memory: combinational read, write on the rising edge.
    assign mem_DR = mem[mem_A[7:2]];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hAABB_CCDD;
        end else if (mem_we) begin
            mem[mem_A[7:2]] <= mem_WD;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT acks or writes memory.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack0 || ack1) begin
                check("ack_exclusive", {31'd0, ack0 & ack1}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: ack0=%0b ack1=%0b at cycle %0d, none expected", ack0, ack1, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_port", {31'd0, ack1}, 32'(e.port));
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.chk_rd) check("rdata", rdata, e.rdata);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: mem_A=%h mem_WD=%h at cycle %0d, none expected", mem_A, mem_WD, cyc);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", mem_A, w.a);
                    check("write_data", mem_WD, w.d);
                end
            end else begin
                check("wd_zero_without_we", mem_WD, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic push_exp(input int p, input logic chk, input logic [31:0] rd, input int c);
        exp_t e;
        e.port = p; e.chk_rd = chk; e.rdata = rd; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a; w.d = d;
        wr_q.push_back(w);
    endtask

    // One isolated transaction with a fixed latency, then one idle cycle.
    task automatic single(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic chk, input logic [31:0] rd, input int lat);
        int c;
        c = cyc;
        drive(p, w, a, d, b);
        push_exp(p, chk, rd, c + lat);
        repeat (lat) tick();
        drop(p);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; mem_load = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_ack0", {31'd0, ack0}, 32'd0);
        check("rst_ack1", {31'd0, ack1}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_A", mem_A, 32'h0);
        check("rst_mem_WD", mem_WD, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        mem_load = 1'b0;
        reset = 1'b0;
        tick();

        // Port 0 read of 0x10
        single(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 2);

        // Port 1 partial write, read-merge-write
        c = cyc;
        drive(1, 1'b1, 32'h22, 32'h1234_0000, 4'b1100);
        push_exp(1, 1'b0, 32'h0, c + 3);
        push_wr(32'h20, 32'h1234_CCDD);
        tick();
        check("merge_access_mem_A", mem_A, 32'h20);
        check("merge_access_we", {31'd0, mem_we}, 32'd0);
        check("merge_access_busy", {31'd0, busy}, 32'd1);
        tick();
        check("merge_cycle_mem_A", mem_A, 32'h20);
        tick();
        drop(1);
        tick();
        check("rdata_hold_after_merge", rdata, 32'hDEAD_BEEF);

        // Full write, then read it back on the other port; read back the merged word
        push_wr(32'h30, 32'hCAFE_F00D);
        single(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 2);
        single(1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 2);
        single(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h1234_CCDD, 2);

        // No-op write: ack after two edges, no memory write
        single(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0, 2);
        check("rdata_hold_after_noop", rdata, 32'h1234_CCDD);

        // Single-byte write on an unaligned address
        push_wr(32'h30, 32'hCAFE_F0AA);
        single(0, 1'b1, 32'h33, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0, 3);

        // Port 0 holds req across its ack while port 1 waits
        c = cyc;
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h30, 32'h0, 4'h0);
        push_exp(0, 1'b1, 32'hDEAD_BEEF, c + 2);
        push_exp(1, 1'b1, 32'hCAFE_F0AA, c + 4);
        tick();
        tick();
        check("hold_ack0_seen", {31'd0, ack0}, 32'd1);
        tick();
        check("hold_port1_access", {31'd0, busy}, 32'd1);
        drop(0);
        tick();
        drop(1);
        tick();
        tick();

        // Starvation: port 1 loses STARVE_LIMIT simultaneous arbitrations
        for (int r = 0; r < STARVE_LIMIT; r++) begin
            c = cyc;
            drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
            drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
            push_exp(0, 1'b1, 32'hDEAD_BEEF, c + 2);
            tick();
            drop(1);
            tick();
            drop(0);
            tick();
        end
        c = cyc;
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
        push_exp(1, 1'b1, 32'h1234_CCDD, c + 2);
        push_exp(0, 1'b1, 32'hDEAD_BEEF, c + 4);
        tick();
        tick();
        drop(1);
        tick();
        tick();
        drop(0);
        tick();
        // Counter cleared by the port-1 grant: port 0 wins again
        c = cyc;
        drive(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
        push_exp(0, 1'b1, 32'hDEAD_BEEF, c + 2);
        tick();
        drop(1);
        tick();
        drop(0);
        tick();

        // Reset during MERGE aborts the write and the ack
        drive(0, 1'b1, 32'h40, 32'h00AB_CD00, 4'b0110);
        tick();
        tick();
        check("abort_merge_busy", {31'd0, busy}, 32'd1);
        check("abort_merge_we", {31'd0, mem_we}, 32'd1);
        check("abort_merge_wd", mem_WD, 32'h10AB_CD10);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_mem_WD", mem_WD, 32'h0);
        check("abort_mem_A", mem_A, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        drop(0);
        tick();
        check("abort_ack0", {31'd0, ack0}, 32'd0);
        reset = 1'b0;
        tick();
        single(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h1000_0010, 2);
        check("abort_mem_untouched", mem[16], 32'h1000_0010);

        tick();
        tick();
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
